// File: rtl/sar_search_ctrl_pkg.sv
// Shared types and constants for the successive-approximation search controller.
// Flag vectors are packed as {A_lt_B, A_gt_B, A_eq_B}.
package sar_search_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_EVAL   = 2'd2
  } state_t;

  localparam logic [2:0] FLAG_LT = 3'b100;
  localparam logic [2:0] FLAG_GT = 3'b010;
  localparam logic [2:0] FLAG_EQ = 3'b001;

  function automatic int max_probes(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// Binary-search controller that drives a registered comparator's B input and
// narrows [lo, hi] on each lt/gt answer until the comparator reports equality.
module sar_search_ctrl
  import sar_search_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          start,
  input  logic                          A_lt_B,
  input  logic                          A_gt_B,
  input  logic                          A_eq_B,
  output logic [WIDTH-1:0]              guess,
  output logic                          busy,
  output logic                          done,
  output logic                          found,
  output logic                          err,
  output logic [WIDTH-1:0]              result,
  output logic [$clog2(WIDTH+2)-1:0]    probes,
  output state_t                        dbg_state
);

  localparam int BW = WIDTH + 1;
  localparam int PW = $clog2(WIDTH + 2);
  localparam logic [PW-1:0] PROBE_MAX = PW'(max_probes(WIDTH));

  // Handshake: start is a level sampled only in IDLE; done is a one-cycle
  // completion pulse coincident with busy falling; found/err/result stay valid
  // from that pulse until the next accepted start.

  state_t            state_q, state_d;
  logic [BW-1:0]     lo_q, lo_d;
  logic [BW-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]  guess_q, guess_d;
  logic [PW-1:0]     probes_q, probes_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              found_q, found_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  result_q, result_d;

  logic [2:0]        flags;
  logic [BW-1:0]     guess_ext;
  logic              step;
  logic              fail;
  logic              finish;

  function automatic logic flags_consistent(input logic [2:0] f);
    return (f == FLAG_LT) || (f == FLAG_GT) || (f == FLAG_EQ);
  endfunction

  // Bounds are one bit wider than guess, so the sum cannot overflow.
  function automatic logic [WIDTH-1:0] midpoint(input logic [BW-1:0] l,
                                                input logic [BW-1:0] h);
    logic [BW:0] s;
    s = {1'b0, l} + {1'b0, h};
    return WIDTH'(s >> 1);
  endfunction

  assign flags     = {A_lt_B, A_gt_B, A_eq_B};
  assign guess_ext = {1'b0, guess_q};

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    probes_d = probes_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    found_d  = found_q;
    err_d    = err_q;
    result_d = result_q;
    step     = 1'b0;
    fail     = 1'b0;
    finish   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = {1'b0, {WIDTH{1'b1}}};
          guess_d  = midpoint('0, {1'b0, {WIDTH{1'b1}}});
          probes_d = PW'(1);
          found_d  = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
          busy_d   = 1'b1;
          state_d  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        state_d = ST_EVAL;
      end

      ST_EVAL: begin
        if (!flags_consistent(flags)) begin
          fail = 1'b1;
        end else if (flags == FLAG_EQ) begin
          result_d = guess_q;
          found_d  = 1'b1;
          finish   = 1'b1;
        end else if (flags == FLAG_GT) begin
          if (guess_ext == hi_q) begin
            fail = 1'b1;
          end else begin
            lo_d = guess_ext + BW'(1);
            step = 1'b1;
          end
        end else begin
          if (guess_ext == lo_q) begin
            fail = 1'b1;
          end else begin
            hi_d = guess_ext - BW'(1);
            step = 1'b1;
          end
        end

        // A narrowed interval still needs a probe slot; running out is an error.
        if (step) begin
          if (probes_q == PROBE_MAX) begin
            fail = 1'b1;
          end else begin
            guess_d  = midpoint(lo_d, hi_d);
            probes_d = probes_q + PW'(1);
            state_d  = ST_SETTLE;
          end
        end

        if (fail) begin
          err_d  = 1'b1;
          finish = 1'b1;
        end

        if (finish) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      guess_q  <= '0;
      probes_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      probes_q <= probes_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign guess     = guess_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign err       = err_q;
  assign result    = result_q;
  assign probes    = probes_q;
  assign dbg_state = state_q;

endmodule
